// File: rtl/cyp_pkg.sv
// cyp_pkg: shared FX2 slave-FIFO constants for the EP2 reader and EP6 writer.
// State codes are common so both FSMs decode alike on the shared bus.
package cyp_pkg;

  typedef logic [4:0] cyp_state_t;

  localparam cyp_state_t CYP_ST_IDLE   = 5'd0;
  localparam cyp_state_t CYP_ST_WAIT   = 5'd1;
  localparam cyp_state_t CYP_ST_WRITE  = 5'd2;
  localparam cyp_state_t CYP_ST_DRAIN  = 5'd3;
  localparam cyp_state_t CYP_ST_PKTEND = 5'd4;
  localparam cyp_state_t CYP_ST_END    = 5'd5;
  localparam cyp_state_t CYP_ST_READ   = 5'd6;

  localparam logic [1:0] CYP_EP2 = 2'b00;
  localparam logic [1:0] CYP_EP6 = 2'b10;

  localparam logic [15:0] USB_EPIN_PKSIZE = 16'd256;
  localparam logic [15:0] CYP_WAIT_CLKS   = 16'd64;
  localparam logic [15:0] PKTEND_TIMEOUT  = 16'd4096;

endpackage

// File: rtl/cyp_ep6_writer_if.sv
// cyp_ep6_writer_if: upstream FIFO read port plus FX2 slave-FIFO pins.
// master = FPGA writer side, slave = FIFO/FX2 side.
interface cyp_ep6_writer_if;

  logic [15:0] src_rdata;
  logic        src_rempty;
  logic        src_ren;
  logic        usb_flagc;
  logic [1:0]  usb_fifoaddr;
  logic        usb_slcs;
  logic        usb_sloe;
  logic        usb_slrd;
  logic        usb_slwr;
  logic        usb_pktend;
  logic [15:0] usb_fd_o;
  logic        usb_fd_oe;

  modport master (
    input  src_rdata,
    input  src_rempty,
    input  usb_flagc,
    output src_ren,
    output usb_fifoaddr,
    output usb_slcs,
    output usb_sloe,
    output usb_slrd,
    output usb_slwr,
    output usb_pktend,
    output usb_fd_o,
    output usb_fd_oe
  );

  modport slave (
    output src_rdata,
    output src_rempty,
    output usb_flagc,
    input  src_ren,
    input  usb_fifoaddr,
    input  usb_slcs,
    input  usb_sloe,
    input  usb_slrd,
    input  usb_slwr,
    input  usb_pktend,
    input  usb_fd_o,
    input  usb_fd_oe
  );

endinterface

// File: rtl/cyp_hold_buf.sv
// cyp_hold_buf: 2-entry 16-bit register FIFO between upstream read and FX2.
// An arriving word is visible at the head the cycle it is pushed.
module cyp_hold_buf
  import cyp_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_push,
  input  logic [15:0] i_data,
  input  logic        i_pop,
  output logic [15:0] o_head,
  output logic [1:0]  o_count,
  output logic        o_avail
);

  logic [15:0] r_mem [0:1];
  logic        r_wr_ptr;
  logic        r_rd_ptr;
  logic [1:0]  r_count;
  logic        w_pass;
  logic        w_wr;
  logic        w_rd;

  // empty + push + pop: the word goes straight through
  assign w_pass  = i_push && i_pop && (r_count == 2'd0);
  assign w_wr    = i_push && !w_pass;
  assign w_rd    = i_pop && !w_pass;
  assign o_count = r_count;
  assign o_avail = (r_count != 2'd0) || i_push;
  assign o_head  = (r_count == 2'd0 && i_push) ? i_data
                                                : r_mem[r_rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= '0;
    end else begin
      if (w_wr) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_rd)
        r_rd_ptr <= ~r_rd_ptr;
      unique case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/cyp_ep6_writer.sv
// cyp_ep6_writer: FX2 slave-FIFO master draining upstream words to EP6 IN.
// Define CYP_PKTEND_TIMEOUT_EN to commit short packets after idle timeout.
module cyp_ep6_writer
  import cyp_pkg::*;
(
  input  logic             cyp_clk,
  input  logic             rst_n,
  input  logic             sdram_init_done,
  output logic             tx_busy,
  cyp_ep6_writer_if.master bus
);

  cyp_state_t  r_state;
  cyp_state_t  w_next;
  logic [15:0] r_wait_cnt;
  logic [15:0] r_issue_cnt;
  logic [15:0] r_wr_cnt;
  logic        r_inflight;
  logic [1:0]  w_hold_cnt;
  logic        w_hold_avail;
  logic [15:0] w_hold_head;
  logic        w_ren;
  logic        w_wr;
  logic        w_fd_oe;
  logic        w_room;
  logic        w_wait_done;
  logic        w_issue_done;
  logic        w_pkt_done;

  // stored + in-flight words never exceed the 2 hold slots
  assign w_room       = ({1'b0, w_hold_cnt} + {2'b00, r_inflight}) < 3'd2;
  assign w_wait_done  = r_wait_cnt == CYP_WAIT_CLKS;
  assign w_issue_done = r_issue_cnt == USB_EPIN_PKSIZE;
  assign w_pkt_done   = w_wr &&
                        (r_wr_cnt == USB_EPIN_PKSIZE - 16'd1);

  cyp_hold_buf u_hold (
    .clk     (cyp_clk),
    .rst_n   (rst_n),
    .i_push  (r_inflight),
    .i_data  (bus.src_rdata),
    .i_pop   (w_wr),
    .o_head  (w_hold_head),
    .o_count (w_hold_cnt),
    .o_avail (w_hold_avail)
  );

`ifdef CYP_PKTEND_TIMEOUT_EN
  logic [15:0] r_idle_cnt;
  logic        w_timeout;

  always_ff @(posedge cyp_clk or negedge rst_n) begin
    if (!rst_n)
      r_idle_cnt <= '0;
    else if (r_state != CYP_ST_WRITE || w_wr)
      r_idle_cnt <= '0;
    else if (r_idle_cnt != 16'hFFFF)
      r_idle_cnt <= r_idle_cnt + 16'd1;
  end

  assign w_timeout = !w_wr &&
                     (r_idle_cnt >= PKTEND_TIMEOUT - 16'd1) &&
                     (w_hold_cnt == 2'd0) && !r_inflight &&
                     (r_wr_cnt != 16'd0);
`endif

  always_ff @(posedge cyp_clk or negedge rst_n) begin
    if (!rst_n)
      r_state <= CYP_ST_IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      CYP_ST_IDLE:
        if (sdram_init_done && !bus.src_rempty && bus.usb_flagc)
          w_next = CYP_ST_WAIT;
      CYP_ST_WAIT:
        if (w_wait_done)
          w_next = CYP_ST_WRITE;
      CYP_ST_WRITE:
        if (w_pkt_done)
          w_next = CYP_ST_END;
        else if (w_issue_done)
          w_next = CYP_ST_DRAIN;
`ifdef CYP_PKTEND_TIMEOUT_EN
        else if (w_timeout)
          w_next = CYP_ST_PKTEND;
`endif
      CYP_ST_DRAIN:
        if (w_pkt_done)
          w_next = CYP_ST_END;
`ifdef CYP_PKTEND_TIMEOUT_EN
      CYP_ST_PKTEND:
        w_next = CYP_ST_END;
`endif
      CYP_ST_END:
        w_next = CYP_ST_IDLE;
      default:
        w_next = CYP_ST_IDLE;
    endcase
  end

  always_comb begin
    w_ren   = 1'b0;
    w_wr    = 1'b0;
    w_fd_oe = 1'b0;
    unique case (1'b1)
      (r_state == CYP_ST_WRITE): begin
        w_ren   = !bus.src_rempty &&
                  (r_issue_cnt < USB_EPIN_PKSIZE) && w_room;
        w_wr    = w_hold_avail && bus.usb_flagc;
        w_fd_oe = 1'b1;
      end
      (r_state == CYP_ST_DRAIN): begin
        w_wr    = w_hold_avail && bus.usb_flagc;
        w_fd_oe = 1'b1;
      end
      (r_state == CYP_ST_PKTEND): begin
        w_fd_oe = 1'b1;
      end
      default: begin
        w_fd_oe = 1'b0;
      end
    endcase
  end

  always_ff @(posedge cyp_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait_cnt  <= '0;
      r_issue_cnt <= '0;
      r_wr_cnt    <= '0;
      r_inflight  <= 1'b0;
    end else begin
      r_inflight <= w_ren;
      if (r_state == CYP_ST_WAIT && !w_wait_done)
        r_wait_cnt <= r_wait_cnt + 16'd1;
      else
        r_wait_cnt <= '0;
      if (r_state == CYP_ST_IDLE || r_state == CYP_ST_WAIT) begin
        r_issue_cnt <= '0;
        r_wr_cnt    <= '0;
      end else begin
        if (w_ren)
          r_issue_cnt <= r_issue_cnt + 16'd1;
        if (w_wr)
          r_wr_cnt <= r_wr_cnt + 16'd1;
      end
    end
  end

  assign bus.src_ren      = w_ren;
  assign bus.usb_fifoaddr = CYP_EP6;
  assign bus.usb_slcs     = 1'b0;
  assign bus.usb_sloe     = 1'b1;
  assign bus.usb_slrd     = 1'b1;
  assign bus.usb_slwr     = !w_wr;
  assign bus.usb_fd_o     = w_hold_head;
  assign bus.usb_fd_oe    = w_fd_oe;
  assign tx_busy          = r_state != CYP_ST_IDLE;

`ifdef CYP_PKTEND_TIMEOUT_EN
  assign bus.usb_pktend = r_state != CYP_ST_PKTEND;
`else
  assign bus.usb_pktend = 1'b1;
`endif

endmodule

// File: doc/cyp_ep6_writer.md
# cyp_ep6_writer

Transmit-side Cypress FX2 (CY68013) slave-FIFO master that drains 16-bit words from an upstream FIFO read port in the cyp_clk domain and writes them into the FX2 EP6 IN FIFO. It pairs with the EP2 OUT reader on the same slave-FIFO bus to carry SDRAM read-back data to the host. Transfers are framed as fixed-size USB packets, paced by the FX2 full flag. A short-packet commit on idle timeout is optional.

## Interface
- USB_EPIN_PKSIZE, 16'd256: words per full packet (512 bytes).
- CYP_WAIT_CLKS, 16'd64: guard cycles between packets.
- PKTEND_TIMEOUT, 16'd4096: idle cycles before a short packet is committed (macro only).
- cyp_clk  in  1  48 MHz IFCLK. Only clock.
- rst_n  in  1  Asynchronous reset, active low.
- sdram_init_done  in  1  Enables packet start.
- src_rdata  in  16  Upstream FIFO data, valid the cycle after src_ren.
- src_rempty  in  1  Upstream FIFO empty.
- src_ren  out  1  Upstream FIFO read strobe.
- usb_flagc  in  1  EP6 full flag: 1 = not full, 0 = full.
- usb_fifoaddr  out  2  Fixed 2'b10 (EP6).
- usb_slcs  out  1  Constant 0.
- usb_sloe  out  1  Constant 1.
- usb_slrd  out  1  Constant 1.
- usb_slwr  out  1  Write strobe, active low.
- usb_pktend  out  1  Packet-end strobe, active low.
- usb_fd_o  out  16  Data to FX2.
- usb_fd_oe  out  1  1 = FPGA drives usb_fd.
- tx_busy  out  1  High in every state except IDLE.

## Operation
- FSM states: IDLE, WAIT, WRITE, DRAIN, PKTEND, END.
- IDLE -> WAIT when sdram_init_done && !src_rempty && usb_flagc.
- WAIT counts wait_cnt 0..CYP_WAIT_CLKS. At CYP_WAIT_CLKS it goes to WRITE and clears both counters.
- WRITE:
  - src_ren = !src_rempty && issue_cnt < USB_EPIN_PKSIZE && hold_cnt + inflight < 2.
  - issue_cnt increments on each src_ren.
- Hold buffer: 2 entries. A word is pushed one cycle after its src_ren. inflight is the registered src_ren.
- Write strobe: usb_slwr = !(state ∈ {WRITE, DRAIN} && hold_cnt != 0 && usb_flagc). This is combinational from registered state and usb_flagc. usb_fd_o is the hold-buffer head.
- Each low usb_slwr cycle pops the head and increments wr_cnt.
- Packet done: usb_slwr low && wr_cnt == USB_EPIN_PKSIZE-1 -> END. The FX2 auto-commits the full packet; no PKTEND is issued.
- WRITE -> DRAIN when issue_cnt == USB_EPIN_PKSIZE. DRAIN only empties the hold buffer.
- END -> IDLE after 1 cycle.
- usb_fd_oe = 1 in WRITE, DRAIN, PKTEND; 0 otherwise.
- Counters are 16 bits; no wrap occurs inside a packet.

## Timing
- Reset values: src_ren 0, usb_slwr 1, usb_pktend 1, usb_fd_o 16'h0000, usb_fd_oe 0, tx_busy 0, usb_fifoaddr 2'b10. All counters 0, hold buffer empty, state IDLE.
- Latency: src_ren at cycle k -> word in hold buffer at k+1 -> usb_slwr low at k+1 if usb_flagc = 1.
- Steady-state rate: 1 word per cycle.
- usb_flagc = 0: usb_slwr deasserts in the same cycle. At most 2 words wait in the hold buffer. No word is lost or duplicated.
- src_rempty mid-packet: reads stall, state stays WRITE, no timeout without the macro.
- Simultaneous push and pop: hold_cnt is unchanged.
- Reset mid-packet: immediate return to IDLE. Strobes deassert asynchronously. The partial packet is abandoned.

## Configuration
- CYP_PKTEND_TIMEOUT_EN defined:
  - In WRITE, if there are no writes for PKTEND_TIMEOUT consecutive cycles, the hold buffer is empty, inflight = 0 and wr_cnt != 0, then go to PKTEND.
  - PKTEND drives usb_pktend low for exactly 1 cycle, then goes to END.
- Not defined: usb_pktend tied 1, no PKTEND state. Only full packets are sent.

## Structure
- Shared package cyp_pkg: state encoding (5-bit localparams, shared with the reader), EP address constants (EP2 = 2'b00, EP6 = 2'b10), USB_EPIN_PKSIZE, CYP_WAIT_CLKS.
- One sub-module: cyp_hold_buf, a 2-entry 16-bit register FIFO with push/pop/count.

## Test plan
- Upstream holds 256 words 0x0000..0x00FF, usb_flagc = 1 -> 64 guard cycles, then 256 consecutive usb_slwr-low cycles carrying 0x0000..0x00FF in order, usb_pktend stays 1, END then IDLE.
- usb_flagc low for 5 cycles after word 0x0010 -> usb_slwr high for those 5 cycles, resume at 0x0011, ≤2 words buffered, 256 words total.
- src_rempty asserted after 100 words for 20 cycles -> 100 writes, a 20-cycle gap, then the remaining 156 writes, no duplicate.
- Macro on, 10 words then upstream empty -> after 4096 idle cycles a single usb_pktend low cycle, then IDLE.
- rst_n low at word 50 -> usb_slwr = 1 and src_ren = 0 asynchronously, state IDLE, counters 0.
- sdram_init_done = 0 with data available -> remains in IDLE, no src_ren.
